stream_demux_1to4: RTL
======================

Name: stream_demux_1to4

Overview:
- Registered 1-to-4 demultiplexer: the distribution-side counterpart of the 4:1 mux.
- Accepts one WIDTH-bit word per cycle on a valid/ready input stream.
- Routes each word to one of four output lanes, chosen either by an explicit select or by an internal round-robin pointer.
- Each lane has a one-entry output register with valid/ready and a saturating transfer counter; the block sits between a shared producer and four independent consumers.

Parameters:
- WIDTH, 4, data word width in bits.
- CNT_W, 8, width of each per-lane transfer counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  WIDTH  word to distribute.
- in_sel  input  2  target lane when rr_en=0.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- rr_en  input  1  1 = round-robin routing, 0 = in_sel routing.
- clear_cnt  input  1  synchronous clear of all transfer counters.
- out_data  output  4*WIDTH  lane k data in bits [k*WIDTH +: WIDTH].
- out_valid  output  4  per-lane data-valid.
- out_ready  input  4  per-lane consumer ready.
- xfer_cnt  output  4*CNT_W  lane k counter in bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, out_data=0, xfer_cnt=0, rr pointer=0.
  - Any held words are discarded; reset mid-operation is not a drain.
- Target lane: tgt = rr_en ? rr_ptr : in_sel.
- Lane k free: !out_valid[k] | out_ready[k].
- in_ready = free(tgt). This is combinational from out_ready, rr_en and in_sel.
- Input transfer = in_valid & in_ready. At the edge, lane tgt loads in_data and sets out_valid[tgt]=1.
- Latency: a word accepted at edge t is visible on its lane from t (registered output, first observable in cycle t+1). Zero bubbles: one word per cycle is sustained when consumers are ready.
- Output handshake = out_valid[k] & out_ready[k]. If lane k is not reloaded on the same edge, out_valid[k] clears.
- Simultaneous drain and load on the same lane: the new word is loaded and out_valid stays 1. This is full throughput.
- Stall: while out_valid[k] & !out_ready[k], out_data lane k holds stable.
- Idle: with in_valid=0 no lane changes except by draining.
- rr pointer:
  - Advances (k -> k+1, 3 -> 0 wrap) only on an input transfer with rr_en=1.
  - Holds when rr_en=0 and resumes from the held value when rr_en returns to 1.
  - Blocked target: a round-robin target whose lane is full stalls the input (in_ready=0). It does not skip to another lane; strict rotation order is guaranteed.
- Counters:
  - xfer_cnt[k] increments on each output handshake of lane k.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clear_cnt=1 forces all counters to 0 and wins over a same-cycle increment.
- Ordering: per lane, words exit in acceptance order. No ordering guarantee across lanes.
- in_sel and in_data are don't-care when in_valid=0.

Decomposition:
- Package demux_pkg:
  - LANES=4, SEL_W=2.
  - typedef lane_idx_t (logic [SEL_W-1:0]).
  - Helper function next_lane() for the wrap increment.
- Sub-module demux_lane_reg, instantiated 4x:
  - Holds one-entry data/valid register plus saturating counter.
  - Inputs: load, load_data, out_ready, clear_cnt.
  - Outputs: data, valid, free, cnt.
- Top level contains only target select, rr pointer and in_ready mux.

Test Plan:
- Reset: drive rst_n=0 with lanes full -> next cycle out_valid=4'b0000, out_data=0, all xfer_cnt=0, rr pointer=0.
- Select routing: rr_en=0, out_ready=4'b1111, send 4'hA sel=2 then 4'h5 sel=0 -> out_data lane2=4'hA valid one cycle, then lane0=4'h5; xfer_cnt lane2=1, lane0=1.
- Round-robin with wrap: rr_en=1, all ready, send 4'h1..4'h6 back-to-back -> lanes receive 1,2,3,4,5,6 on lanes 0,1,2,3,0,1. in_ready stays 1 throughout; lane0 cnt=2.
- Backpressure stall: rr_en=0, out_ready[1]=0, send 4'h7 then 4'h8 both sel=1 -> 4'h7 held stable and in_ready=0 for the second word. Raise out_ready[1] -> same edge drains 4'h7 and loads 4'h8, out_valid[1] stays 1.
- Blocked round-robin: rr_en=1, pointer=3, lane3 full and not ready, in_valid=1 -> in_ready=0 and pointer stays 3. Lane0 does not receive the word.
- Counter saturation and clear: CNT_W=8, 260 drains on lane0 -> cnt=255. Assert clear_cnt in a drain cycle -> cnt=0.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared lane count, lane index type and pointer-wrap helper
//               for the 1-to-4 stream demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] lane_idx_t;

  // The index is exactly SEL_W bits wide, so 3 -> 0 wraps naturally.
  function automatic lane_idx_t next_lane(input lane_idx_t cur);
    return cur + lane_idx_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_lane_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_lane_reg
// Description : One output lane. It holds a one-entry data/valid register
//               with a valid/ready handshake and a saturating transfer
//               counter that counts output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_lane_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  input  logic             clear_cnt,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign w_drain = r_valid & out_ready;

  // The slot can take a new word when it is empty or is draining this cycle.
  assign free  = ~r_valid | out_ready;
  assign data  = r_data;
  assign valid = r_valid;
  assign cnt   = r_cnt;

  // Data/valid register. A load takes priority over a drain, so a
  // simultaneous drain and load keeps valid high for full throughput.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating handshake counter. A clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear_cnt) begin
      r_cnt <= '0;
    end else if (w_drain && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_demux_1to4.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1to4
// Description : Registered 1-to-4 stream demultiplexer. Each accepted word
//               is routed to one lane, chosen by in_sel or by a strict
//               round-robin pointer. A full target lane stalls the input.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1to4
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   rr_en,
  input  logic                   clear_cnt,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*CNT_W-1:0] xfer_cnt
);

  lane_idx_t        r_ptr;
  lane_idx_t        w_tgt;
  logic [LANES-1:0] w_free;
  logic [LANES-1:0] w_load;
  logic             w_xfer;

  // The target lane never skips: a blocked round-robin lane stalls the input.
  assign w_tgt    = rr_en ? r_ptr : lane_idx_t'(in_sel);
  assign in_ready = w_free[w_tgt];
  assign w_xfer   = in_valid & in_ready;

  // The round-robin pointer moves only on an accepted word in round-robin mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer && rr_en) begin
      r_ptr <= next_lane(r_ptr);
    end
  end

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_load[k] = w_xfer & (w_tgt == lane_idx_t'(k));

      demux_lane_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load[k]),
        .load_data (in_data),
        .out_ready (out_ready[k]),
        .clear_cnt (clear_cnt),
        .data      (out_data[k*WIDTH +: WIDTH]),
        .valid     (out_valid[k]),
        .free      (w_free[k]),
        .cnt       (xfer_cnt[k*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule
`default_nettype wire
